// File: rtl/pulpino_boot_sequencer.sv
// Bench-side boot controller for PULPino: holds the chip in reset, releases it,
// streams program words into the SPI slave as write frames, then raises fetch_enable.
module pulpino_boot_sequencer #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned RESET_CYCLES = 16,
  parameter logic [7:0]  SPI_WR_CMD   = 8'h02
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        word_valid,
  output logic        word_ready,
  input  logic [31:0] word_addr,
  input  logic [31:0] word_data,
  input  logic        word_last,
  output logic        chip_rst_n,
  output logic        fetch_enable,
  output logic        spi_sck,
  output logic        spi_csn,
  output logic        spi_mosi,
  output logic        busy,
  output logic        done,
  output logic [15:0] words_sent
);
  localparam int FRAME_W = 72;
  localparam int RW      = $clog2(RESET_CYCLES + 1);
  localparam int DW      = $clog2(CLK_DIV + 2);
  localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] GAP_LAST = DW'(CLK_DIV);
  localparam logic [6:0]    BIT_LAST = 7'(FRAME_W - 1);

  typedef enum logic [3:0] {
    IDLE, RST_HOLD, RST_WAIT, FETCH, CS_SETUP, SHIFT, CS_HOLD, GAP, BOOT, DONE
  } state_t;

  state_t               state, state_d;
  logic [RW-1:0]        rcnt, rcnt_d;
  logic [DW-1:0]        dcnt, dcnt_d;
  logic [6:0]           bit_cnt, bit_d;
  logic                 hi, hi_d;
  logic [FRAME_W-1:0]   frame, frame_d;
  logic                 last, last_d;
  logic [15:0]          ws_d;
  logic                 accept;

  assign accept = word_valid && word_ready;

  always_comb begin
    state_d = state;
    rcnt_d  = rcnt;
    dcnt_d  = dcnt;
    bit_d   = bit_cnt;
    hi_d    = hi;
    frame_d = frame;
    last_d  = last;
    ws_d    = words_sent;
    case (state)
      IDLE, DONE: if (start) begin
        state_d = RST_HOLD;
        rcnt_d  = '0;
        ws_d    = '0;
      end
      RST_HOLD, RST_WAIT: begin
        rcnt_d = rcnt + 1'b1;
        if (rcnt == RST_LAST) begin
          rcnt_d  = '0;
          state_d = (state == RST_HOLD) ? RST_WAIT : FETCH;
        end
      end
      FETCH: if (accept) begin
        state_d = CS_SETUP;
        frame_d = {SPI_WR_CMD, word_addr, word_data};
        last_d  = word_last;
        dcnt_d  = '0;
        hi_d    = 1'b0;
      end
      CS_SETUP: begin
        dcnt_d = dcnt + 1'b1;
        if (dcnt == DIV_LAST) begin
          state_d = SHIFT;
          dcnt_d  = '0;
          bit_d   = '0;
          hi_d    = 1'b0;
        end
      end
      SHIFT: begin
        dcnt_d = dcnt + 1'b1;
        if (dcnt == DIV_LAST) begin
          dcnt_d = '0;
          hi_d   = !hi;
          // The next bit is presented on the same cycle sck falls.
          if (hi) begin
            if (bit_cnt == BIT_LAST) state_d = CS_HOLD;
            else begin
              bit_d   = bit_cnt + 1'b1;
              frame_d = {frame[FRAME_W-2:0], 1'b0};
            end
          end
        end
      end
      CS_HOLD: begin
        dcnt_d = dcnt + 1'b1;
        if (dcnt == DIV_LAST) begin
          state_d = GAP;
          dcnt_d  = '0;
          if (words_sent != 16'hFFFF) ws_d = words_sent + 16'd1;
        end
      end
      GAP: begin
        // One cycle beyond CLK_DIV closes out the frame before the next decision.
        dcnt_d = dcnt + 1'b1;
        if (dcnt == GAP_LAST) begin
          dcnt_d  = '0;
          state_d = last ? BOOT : FETCH;
        end
      end
      BOOT:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rcnt         <= '0;
      dcnt         <= '0;
      bit_cnt      <= '0;
      hi           <= 1'b0;
      frame        <= '0;
      last         <= 1'b0;
      words_sent   <= '0;
      chip_rst_n   <= 1'b0;
      fetch_enable <= 1'b0;
      spi_sck      <= 1'b0;
      spi_csn      <= 1'b1;
      spi_mosi     <= 1'b0;
      word_ready   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_d;
      rcnt         <= rcnt_d;
      dcnt         <= dcnt_d;
      bit_cnt      <= bit_d;
      hi           <= hi_d;
      frame        <= frame_d;
      last         <= last_d;
      words_sent   <= ws_d;
      chip_rst_n   <= !(state_d inside {IDLE, RST_HOLD});
      fetch_enable <= state_d inside {BOOT, DONE};
      spi_sck      <= (state_d == SHIFT) && hi_d;
      spi_csn      <= !(state_d inside {CS_SETUP, SHIFT, CS_HOLD});
      spi_mosi     <= (state_d inside {CS_SETUP, SHIFT}) && frame_d[FRAME_W-1];
      word_ready   <= state_d == FETCH;
      busy         <= !(state_d inside {IDLE, DONE});
      done         <= state_d == DONE;
    end
  end
endmodule
